// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the single-port peripheral bus, with locked bursts and registered read return.
// Optional address range/alignment checking is enabled by defining ARB_ADDR_CHECK_EN.
module periph_bus_arbiter #(
    parameter int unsigned MAX_BURST   = 4,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
    parameter logic [31:0] PERIPH_TOP  = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m_req,
    input  logic [1:0]  m_lock,
    input  logic [1:0]  m_wr,
    input  logic [31:0] m_addr0,
    input  logic [31:0] m_addr1,
    input  logic [31:0] m_wdata0,
    input  logic [31:0] m_wdata1,
    output logic [1:0]  m_gnt,
    output logic [1:0]  m_rvalid,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_err,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    // state | meaning
    // IDLE  | nobody owns the bus, no access
    // OWN0  | M0 owns the bus, granted whenever m_req[0] is high
    // OWN1  | M1 owns the bus, granted whenever m_req[1] is high
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

`ifdef ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

    state_t      state, state_nxt;
    logic        last_own, last_nxt;
    logic [3:0]  burst_cnt, burst_nxt;
    logic        granting, sel, addr_bad;
    logic [31:0] sel_addr;

    assign sel_addr = (state == OWN1) ? m_addr1 : m_addr0;
    assign addr_bad = ADDR_CHECK & ((sel_addr < PERIPH_BASE) | (sel_addr > PERIPH_TOP) |
                                    (sel_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_own  <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last_own  <= last_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // The tie-break uses last_own including this cycle's grant, so contention alternates.
    always_comb begin
        state_nxt = state;
        burst_nxt = '0;
        last_nxt  = last_own;
        if (granting) last_nxt = sel;
        if (granting && m_lock[sel] && (burst_cnt < BURST_LIM)) begin
            burst_nxt = burst_cnt + 4'd1;
        end else begin
            unique case (m_req)
                2'b11:   state_nxt = last_nxt ? OWN0 : OWN1;
                2'b01:   state_nxt = OWN0;
                2'b10:   state_nxt = OWN1;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        granting = 1'b0;
        sel      = 1'b0;
        m_gnt    = '0;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        wdata    = '0;
        if (state == OWN0 && m_req[0]) begin
            granting = 1'b1;
            sel      = 1'b0;
        end else if (state == OWN1 && m_req[1]) begin
            granting = 1'b1;
            sel      = 1'b1;
        end
        if (granting) begin
            m_gnt[sel] = 1'b1;
            addr       = sel_addr;
            wdata      = sel ? m_wdata1 : m_wdata0;
            rd         = ~m_wr[sel] & ~addr_bad;
            wr         = m_wr[sel] & ~addr_bad;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rvalid <= '0;
            m_rdata  <= '0;
            m_err    <= '0;
        end else begin
            m_rvalid <= '0;
            m_err    <= '0;
            if (granting) begin
                if (addr_bad) begin
                    m_rvalid[sel] <= 1'b1;
                    m_err[sel]    <= 1'b1;
                    m_rdata       <= '0;
                end else if (!m_wr[sel]) begin
                    m_rvalid[sel] <= 1'b1;
                    m_rdata       <= rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: tests push expected grants/responses, a negedge monitor checks them.
// Peripheral model returns {24'h0, addr[7:0] ^ 8'hB5}; expected read data below is precomputed from it.
module tb_periph_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, lock0, lock1, wr0, wr1;
    logic [31:0] m_addr0, m_addr1, m_wdata0, m_wdata1;
    logic [1:0]  m_gnt, m_rvalid, m_err;
    logic [31:0] m_rdata;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic        m;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        bad;
    } gnt_t;
    typedef struct {
        logic        m;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];

    periph_bus_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .m_req    ({req1, req0}),
        .m_lock   ({lock1, lock0}),
        .m_wr     ({wr1, wr0}),
        .m_addr0  (m_addr0),
        .m_addr1  (m_addr1),
        .m_wdata0 (m_wdata0),
        .m_wdata1 (m_wdata1),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .m_err    (m_err),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata)
    );

    assign rdata = {24'h0, addr[7:0] ^ 8'hB5};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (m_gnt != 2'b00) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", {30'h0, m_gnt}, 32'h0);
                end else begin
                    gnt_t g;
                    g = gq.pop_front();
                    chk("gnt_master", {30'h0, m_gnt}, g.m ? 32'h2 : 32'h1);
                    chk("bus_addr",   addr,  g.a);
                    chk("bus_wdata",  wdata, g.d);
                    chk("bus_rd",     {31'h0, rd}, {31'h0, !g.w && !g.bad});
                    chk("bus_wr",     {31'h0, wr}, {31'h0, g.w && !g.bad});
                end
            end
            if (m_rvalid != 2'b00) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", {30'h0, m_rvalid}, 32'h0);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    chk("rsp_master", {30'h0, m_rvalid}, r.m ? 32'h2 : 32'h1);
                    chk("rsp_rdata",  m_rdata, r.data);
                    chk("rsp_err",    {30'h0, m_err}, r.err ? (r.m ? 32'h2 : 32'h1) : 32'h0);
                end
            end else begin
                chk("err_without_rvalid", {30'h0, m_err}, 32'h0);
            end
        end
    end

    task automatic m_access(input bit k, input logic w, input logic lk,
                            input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        if (k == 1'b0) begin
            req0 = 1'b1; wr0 = w; lock0 = lk; m_addr0 = a; m_wdata0 = d;
        end else begin
            req1 = 1'b1; wr1 = w; lock1 = lk; m_addr1 = a; m_wdata1 = d;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_gnt[k]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL m%0d_gnt_timeout: got no grant expected grant within 100 cycles", k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic m_idle(input bit k);
        if (k == 1'b0) begin req0 = 1'b0; lock0 = 1'b0; end
        else           begin req1 = 1'b0; lock1 = 1'b0; end
    endtask

    task automatic push_g(input logic m, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic bad);
        gnt_t g;
        g.m = m; g.w = w; g.a = a; g.d = d; g.bad = bad;
        gq.push_back(g);
    endtask

    task automatic push_r(input logic m, input logic [31:0] data, input logic err);
        rsp_t r;
        r.m = m; r.data = data; r.err = err;
        rq.push_back(r);
    endtask

    task automatic gap();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        reset = 1'b0;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; wr0 = 0; wr1 = 0;
        m_addr0 = '0; m_addr1 = '0; m_wdata0 = '0; m_wdata1 = '0;
        #12;
        chk("rst_gnt",    {30'h0, m_gnt}, 32'h0);
        chk("rst_rd_wr",  {30'h0, rd, wr}, 32'h0);
        chk("rst_addr",   addr, 32'h0);
        chk("rst_wdata",  wdata, 32'h0);
        chk("rst_rvalid", {30'h0, m_rvalid}, 32'h0);
        chk("rst_rdata",  m_rdata, 32'h0);
        chk("rst_err",    {30'h0, m_err}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted while M0 is being granted back-to-back reads
        @(posedge clk); #1;
        req0 = 1'b1; wr0 = 1'b0; m_addr0 = 32'h4000_0004; m_wdata0 = '0;
        repeat (3) @(negedge clk);
        chk("t1_gnt_before",    {30'h0, m_gnt}, 32'h1);
        chk("t1_rvalid_before", {30'h0, m_rvalid}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("t1_gnt",    {30'h0, m_gnt}, 32'h0);
        chk("t1_rd_wr",  {30'h0, rd, wr}, 32'h0);
        chk("t1_rvalid", {30'h0, m_rvalid}, 32'h0);
        chk("t1_rdata",  m_rdata, 32'h0);
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t1_lost_rvalid", {30'h0, m_rvalid}, 32'h0);
        chk("t1_idle_gnt",    {30'h0, m_gnt}, 32'h0);
        gq.delete();
        rq.delete();
        mon_en = 1'b1;

        // Contention without lock: strict alternation, M0 first after reset
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            push_g(1'b0, 1'b1, 32'h4000_0000 + 32'(4 * i), 32'h100 + 32'(i), 1'b0);
            push_g(1'b1, 1'b1, 32'h4000_0010 + 32'(4 * i), 32'h200 + 32'(i), 1'b0);
        end
        fork
            begin
                for (int i = 0; i < 4; i++)
                    m_access(1'b0, 1'b1, 1'b0, 32'h4000_0000 + 32'(4 * i), 32'h100 + 32'(i));
                m_idle(1'b0);
            end
            begin
                for (int j = 0; j < 4; j++)
                    m_access(1'b1, 1'b1, 1'b0, 32'h4000_0010 + 32'(4 * j), 32'h200 + 32'(j));
                m_idle(1'b1);
            end
        join
        gap();

        // Single M0 read: grant at N+1, response at N+2
        push_g(1'b0, 1'b0, 32'h4000_0010, 32'h0, 1'b0);
        push_r(1'b0, 32'h0000_00A5, 1'b0);
        req0 = 1'b1; wr0 = 1'b0; m_addr0 = 32'h4000_0010; m_wdata0 = '0;
        @(negedge clk);
        chk("t2_gnt_n",  {30'h0, m_gnt}, 32'h0);
        @(negedge clk);
        chk("t2_gnt_n1", {30'h0, m_gnt}, 32'h1);
        @(posedge clk); #1;
        m_idle(1'b0);
        @(negedge clk);
        chk("t2_rvalid", {30'h0, m_rvalid}, 32'h1);
        chk("t2_rdata",  m_rdata, 32'h0000_00A5);
        gap();

        // M0 alone, three back-to-back reads with no bubble
        push_g(1'b0, 1'b0, 32'h4000_0008, 32'h0, 1'b0);
        push_g(1'b0, 1'b0, 32'h4000_000C, 32'h0, 1'b0);
        push_g(1'b0, 1'b0, 32'h4000_0014, 32'h0, 1'b0);
        push_r(1'b0, 32'h0000_00BD, 1'b0);
        push_r(1'b0, 32'h0000_00B9, 1'b0);
        push_r(1'b0, 32'h0000_00A1, 1'b0);
        c0 = cyc;
        m_access(1'b0, 1'b0, 1'b0, 32'h4000_0008, 32'h0);
        m_access(1'b0, 1'b0, 1'b0, 32'h4000_000C, 32'h0);
        m_access(1'b0, 1'b0, 1'b0, 32'h4000_0014, 32'h0);
        m_idle(1'b0);
        chk("t5_cycles", 32'(cyc - c0), 32'd4);
        gap();

        // M1 locked burst vs M0: last owner was M0, so M1 wins, holds 4 grants, then M0, then M1
        for (int i = 0; i < 4; i++)
            push_g(1'b1, 1'b1, 32'h4000_0004 + 32'(4 * i), 32'h300 + 32'(i), 1'b0);
        push_g(1'b0, 1'b0, 32'h4000_0020, 32'h0, 1'b0);
        push_g(1'b1, 1'b1, 32'h4000_0014, 32'h304, 1'b0);
        push_r(1'b0, 32'h0000_0095, 1'b0);
        fork
            begin
                m_access(1'b0, 1'b0, 1'b0, 32'h4000_0020, 32'h0);
                m_idle(1'b0);
            end
            begin
                for (int j = 0; j < 5; j++)
                    m_access(1'b1, 1'b1, 1'b1, 32'h4000_0004 + 32'(4 * j), 32'h300 + 32'(j));
                m_idle(1'b1);
            end
        join
        gap();

        // M1 write outside the peripheral window
`ifdef ARB_ADDR_CHECK_EN
        push_g(1'b1, 1'b1, 32'h4000_0040, 32'hDEAD_BEEF, 1'b1);
        push_r(1'b1, 32'h0, 1'b1);
`else
        push_g(1'b1, 1'b1, 32'h4000_0040, 32'hDEAD_BEEF, 1'b0);
`endif
        m_access(1'b1, 1'b1, 1'b0, 32'h4000_0040, 32'hDEAD_BEEF);
        m_idle(1'b1);
        gap();

        chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
